// File: rtl/ram_pkg.sv
// Shared definitions for the banked RAM controller: FSM state encoding and
// a constant-foldable ceil(log2) helper for deriving address widths.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One storage bank: 2**BANK_AW words of WSIZE bytes, per-byte write enables,
// registered read data. Behavioural model, interchangeable with a hard macro.
module ram_bank #(
    parameter int unsigned WSIZE   = 1,
    parameter int unsigned BANK_AW = 7,
    localparam int unsigned DW     = 8 * WSIZE,
    localparam int unsigned DEPTH  = 2 ** BANK_AW
) (
    input  logic               i_clk,
    input  logic               i_en,
    input  logic [WSIZE-1:0]   i_we,
    input  logic [BANK_AW-1:0] i_addr,
    input  logic [DW-1:0]      i_din,
    output logic [DW-1:0]      o_dout
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_dout;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (|i_we) begin
                for (int unsigned b = 0; b < WSIZE; b++) begin
                    if (i_we[b]) begin
                        r_mem[i_addr][8*b +: 8] <= i_din[8*b +: 8];
                    end
                end
            end else begin
                r_dout <= r_mem[i_addr];
            end
        end
    end

    always_comb begin
        o_dout = r_dout;
    end

endmodule

// File: rtl/ram_banked_ctrl.sv
// Banked RAM front end: ready/valid request port, per-bank enables, registered
// read data with bank-select mux, and a zeroising clear sequencer.
module ram_banked_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned WSIZE          = 1,
    parameter int unsigned BANK_AW        = 7,
    parameter int unsigned NUM_BANKS      = 2,
    parameter int unsigned CLEAR_ON_RESET = 1,
    localparam int unsigned DW            = 8 * WSIZE,
    localparam int unsigned BSW           = clog2(NUM_BANKS),
    localparam int unsigned AW            = BANK_AW + BSW
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN0,
    input  logic [WSIZE-1:0] WE0,
    input  logic [AW-1:0]    A0,
    input  logic [DW-1:0]    Di0,
    output logic             READY0,
    output logic [DW-1:0]    Do0,
    output logic             VALID0,
    input  logic             CLR_REQ,
    output logic             BUSY
);

    localparam int unsigned SELW = (BSW == 0) ? 1 : BSW;

    state_t               r_state;
    logic [BANK_AW-1:0]   r_cnt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_valid;
    logic                 r_have_rd;
    logic [SELW-1:0]      r_rd_sel;

    logic                 w_clearing;
    logic                 w_accept;
    logic                 w_write;
    logic                 w_read;
    logic [SELW-1:0]      w_bank_sel;
    logic [NUM_BANKS-1:0] w_en;
    logic [WSIZE-1:0]     w_we;
    logic [BANK_AW-1:0]   w_addr;
    logic [DW-1:0]        w_din;
    logic [DW-1:0]        w_dout [NUM_BANKS];

    if (BSW > 0) begin : g_sel
        always_comb begin
            w_bank_sel = A0[AW-1:BANK_AW];
        end
    end else begin : g_nosel
        always_comb begin
            w_bank_sel = '0;
        end
    end

    always_comb begin
        w_clearing = (r_state == ST_CLEAR);
        w_accept   = EN0 && r_ready;
        w_write    = |WE0;
        w_read     = w_accept && !w_write;
        w_addr     = w_clearing ? r_cnt : A0[BANK_AW-1:0];
        w_din      = w_clearing ? '0 : Di0;
        w_we       = w_clearing ? '1 : WE0;
        w_en       = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            w_en[b] = w_clearing || (w_accept && (w_bank_sel == SELW'(b)));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank #(
            .WSIZE   (WSIZE),
            .BANK_AW (BANK_AW)
        ) u_bank (
            .i_clk  (CLK),
            .i_en   (w_en[g]),
            .i_we   (w_we),
            .i_addr (w_addr),
            .i_din  (w_din),
            .o_dout (w_dout[g])
        );
    end

    // READY0/BUSY are registered alongside the state so they never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (CLR_REQ) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == '1) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_valid   <= 1'b0;
            r_have_rd <= 1'b0;
            r_rd_sel  <= '0;
        end else begin
            r_valid <= w_read;
            if (w_read) begin
                r_have_rd <= 1'b1;
                r_rd_sel  <= w_bank_sel;
            end
        end
    end

    // Bank output registers have no reset; gating keeps Do0 at zero until the
    // first read after reset completes, then it tracks the last-read bank.
    always_comb begin
        READY0 = r_ready;
        BUSY   = r_busy;
        VALID0 = r_valid;
        Do0    = r_have_rd ? w_dout[r_rd_sel] : '0;
    end

endmodule

// File: tb/tb_ram_banked_ctrl.sv
// Directed bench for ram_banked_ctrl: three configurations (2x128x8, 2x128x32,
// 4x16x8) driven from a vector table plus hand-written clear/reset sequences.
module tb_ram_banked_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Config A: WSIZE=1, BANK_AW=7, NUM_BANKS=2
    logic       a_rst, a_en, a_clr, a_ready, a_valid, a_busy;
    logic [0:0] a_we;
    logic [7:0] a_addr, a_di, a_do;
    // Config B: WSIZE=4, BANK_AW=7, NUM_BANKS=2
    logic        b_rst, b_en, b_clr, b_ready, b_valid, b_busy;
    logic [3:0]  b_we;
    logic [7:0]  b_addr;
    logic [31:0] b_di, b_do;
    // Config C: WSIZE=1, BANK_AW=4, NUM_BANKS=4
    logic       c_rst, c_en, c_clr, c_ready, c_valid, c_busy;
    logic [0:0] c_we;
    logic [5:0] c_addr;
    logic [7:0] c_di, c_do;

    ram_banked_ctrl #(.WSIZE(1), .BANK_AW(7), .NUM_BANKS(2), .CLEAR_ON_RESET(1)) u_a (
        .CLK(clk), .RST(a_rst), .EN0(a_en), .WE0(a_we), .A0(a_addr), .Di0(a_di),
        .READY0(a_ready), .Do0(a_do), .VALID0(a_valid), .CLR_REQ(a_clr), .BUSY(a_busy));

    ram_banked_ctrl #(.WSIZE(4), .BANK_AW(7), .NUM_BANKS(2), .CLEAR_ON_RESET(1)) u_b (
        .CLK(clk), .RST(b_rst), .EN0(b_en), .WE0(b_we), .A0(b_addr), .Di0(b_di),
        .READY0(b_ready), .Do0(b_do), .VALID0(b_valid), .CLR_REQ(b_clr), .BUSY(b_busy));

    ram_banked_ctrl #(.WSIZE(1), .BANK_AW(4), .NUM_BANKS(4), .CLEAR_ON_RESET(1)) u_c (
        .CLK(clk), .RST(c_rst), .EN0(c_en), .WE0(c_we), .A0(c_addr), .Di0(c_di),
        .READY0(c_ready), .Do0(c_do), .VALID0(c_valid), .CLR_REQ(c_clr), .BUSY(c_busy));

    typedef struct {
        int          dut;
        logic        en;
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] di;
        logic        exp_v;
        logic [31:0] exp_do;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int dut, input logic en, input logic [3:0] we,
                                input logic [7:0] addr, input logic [31:0] di,
                                input logic ev, input logic [31:0] ed);
        vec_t v;
        v.dut = dut; v.en = en; v.we = we; v.addr = addr; v.di = di;
        v.exp_v = ev; v.exp_do = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int dut, input logic en, input logic [3:0] we,
                         input logic [7:0] addr, input logic [31:0] di);
        a_en = 1'b0; b_en = 1'b0; c_en = 1'b0;
        case (dut)
            0: begin a_en = en; a_we = we[0:0]; a_addr = addr; a_di = di[7:0]; end
            1: begin b_en = en; b_we = we; b_addr = addr; b_di = di; end
            default: begin c_en = en; c_we = we[0:0]; c_addr = addr[5:0]; c_di = di[7:0]; end
        endcase
    endtask

    function automatic logic [31:0] get_do(input int dut);
        case (dut)
            0: return {24'h0, a_do};
            1: return b_do;
            default: return {24'h0, c_do};
        endcase
    endfunction

    function automatic logic get_valid(input int dut);
        case (dut)
            0: return a_valid;
            1: return b_valid;
            default: return c_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int dut);
        case (dut)
            0: return a_ready;
            1: return b_ready;
            default: return c_ready;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int stray;
        int vcount;

        a_rst = 1; b_rst = 1; c_rst = 1;
        a_clr = 0; b_clr = 0; c_clr = 0;
        a_en = 0; a_we = '0; a_addr = '0; a_di = '0;
        b_en = 0; b_we = '0; b_addr = '0; b_di = '0;
        c_en = 0; c_we = '0; c_addr = '0; c_di = '0;

        // Table: test 1 (reads after clear), test 2 (bank isolation, RAW), test 3 (byte enables)
        tbl.push_back(mk(0, 1, 4'h0, 8'h00, 32'h0, 1, 32'h00));
        tbl.push_back(mk(0, 1, 4'h0, 8'h7F, 32'h0, 1, 32'h00));
        tbl.push_back(mk(0, 1, 4'h0, 8'h80, 32'h0, 1, 32'h00));
        tbl.push_back(mk(0, 1, 4'h0, 8'hFF, 32'h0, 1, 32'h00));
        tbl.push_back(mk(0, 1, 4'h1, 8'h03, 32'hA5, 0, 32'h00));
        tbl.push_back(mk(0, 1, 4'h1, 8'h83, 32'h5A, 0, 32'h00));
        tbl.push_back(mk(0, 1, 4'h0, 8'h03, 32'h0, 1, 32'hA5));
        tbl.push_back(mk(0, 1, 4'h0, 8'h83, 32'h0, 1, 32'h5A));
        tbl.push_back(mk(0, 0, 4'h0, 8'h00, 32'h0, 0, 32'h5A));
        tbl.push_back(mk(0, 1, 4'h1, 8'h10, 32'h3C, 0, 32'h5A));
        tbl.push_back(mk(0, 1, 4'h0, 8'h10, 32'h0, 1, 32'h3C));
        tbl.push_back(mk(0, 1, 4'h0, 8'h90, 32'h0, 1, 32'h00));
        tbl.push_back(mk(1, 1, 4'hF, 8'h10, 32'h11223344, 0, 32'h0));
        tbl.push_back(mk(1, 1, 4'h4, 8'h10, 32'hFFFFFFFF, 0, 32'h0));
        tbl.push_back(mk(1, 1, 4'h0, 8'h10, 32'h0, 1, 32'h11FF3344));
        tbl.push_back(mk(1, 1, 4'h1, 8'h10, 32'hDEADBEAA, 0, 32'h11FF3344));
        tbl.push_back(mk(1, 1, 4'hF, 8'h90, 32'h12345678, 0, 32'h11FF3344));
        tbl.push_back(mk(1, 1, 4'h0, 8'h10, 32'h0, 1, 32'h11FF33AA));
        tbl.push_back(mk(1, 1, 4'h0, 8'h90, 32'h0, 1, 32'h12345678));
        tbl.push_back(mk(1, 0, 4'h0, 8'h00, 32'h0, 0, 32'h12345678));

        repeat (3) @(negedge clk);
        chk("rst ready", a_ready, 0);
        chk("rst busy", a_busy, 1);
        chk("rst valid", a_valid, 0);
        chk("rst do", a_do, 0);
        a_rst = 0; b_rst = 0; c_rst = 0;

        n = 0;
        while (a_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("init busy cycles", n, 128);
        chk("init ready", a_ready, 1);
        chk("b ready", b_ready, 1);
        chk("c ready", c_ready, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].dut, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].di);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), get_valid(tbl[i].dut), tbl[i].exp_v);
            chk($sformatf("vec%0d do", i), get_do(tbl[i].dut), tbl[i].exp_do);
            chk($sformatf("vec%0d ready", i), get_ready(tbl[i].dut), 1);
        end
        drive(0, 0, 4'h0, 8'h00, 32'h0);

        // Test 4: read together with clear request returns pre-clear data
        drive(0, 1, 4'h1, 8'h05, 32'h77);
        @(negedge clk);
        drive(0, 1, 4'h0, 8'h05, 32'h0);
        a_clr = 1;
        @(negedge clk);
        a_clr = 0;
        chk("clr read valid", a_valid, 1);
        chk("clr read do", a_do, 8'h77);
        chk("clr busy", a_busy, 1);
        n = 1;
        stray = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (!a_busy) break;
            n++;
            if (a_valid) stray++;
            a_clr = (n == 10);
        end
        a_clr = 0;
        chk("clr busy cycles", n, 128);
        chk("clr stray valid", stray, 0);
        chk("clr ready after", a_ready, 1);
        @(negedge clk);
        chk("held read valid", a_valid, 1);
        chk("held read do", a_do, 8'h00);
        drive(0, 0, 4'h0, 8'h00, 32'h0);

        // Test 5: reset in the middle of a clear
        drive(0, 1, 4'h1, 8'h07, 32'h99);
        @(negedge clk);
        drive(0, 1, 4'h1, 8'hF0, 32'hC3);
        @(negedge clk);
        drive(0, 1, 4'h0, 8'h07, 32'h0);
        @(negedge clk);
        chk("pre5 do", a_do, 8'h99);
        drive(0, 1, 4'h0, 8'hF0, 32'h0);
        a_clr = 1;
        @(negedge clk);
        a_clr = 0;
        drive(0, 0, 4'h0, 8'h00, 32'h0);
        chk("pre5 read do", a_do, 8'hC3);
        repeat (39) @(negedge clk);
        #2 a_rst = 1;
        #1;
        chk("midrst valid", a_valid, 0);
        chk("midrst do", a_do, 0);
        chk("midrst busy", a_busy, 1);
        chk("midrst ready", a_ready, 0);
        @(negedge clk);
        a_rst = 0;
        n = 0;
        while (a_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        chk("reclear busy cycles", n, 128);
        for (int i = 0; i < 256; i++) begin
            drive(0, 1, 4'h0, 8'(i), 32'h0);
            @(negedge clk);
            chk($sformatf("zero%0d valid", i), a_valid, 1);
            chk($sformatf("zero%0d do", i), a_do, 0);
        end
        drive(0, 0, 4'h0, 8'h00, 32'h0);

        // Test 6: four banks of 16 words, address pattern
        for (int i = 0; i < 64; i++) begin
            drive(2, 1, 4'h1, 8'(i), 32'(i));
            @(negedge clk);
        end
        vcount = 0;
        for (int i = 0; i < 64; i++) begin
            drive(2, 1, 4'h0, 8'(i), 32'h0);
            @(negedge clk);
            if (c_valid) vcount++;
            chk($sformatf("pat%0d do", i), c_do, 32'(i));
        end
        drive(2, 0, 4'h0, 8'h00, 32'h0);
        @(negedge clk);
        if (c_valid) vcount++;
        chk("pat valid count", vcount, 64);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
